trigger_capture_buffer: RTL
===========================

// Module: trigger_capture_buffer
// PURPOSE
//  Multi-channel circular sample buffer with arm/trigger/post-trigger capture.
//  Continuously records pre-trigger history. After a trigger it stores a
//  programmable number of extra samples, then freezes for random-access readout.
//  Feeds the correlator/windowing stage and supersedes the fixed 16-bit stop-driven buffer.
// PARAMETERS
//  DATA_W   16   bits per channel sample
//  CHANNELS 1    channels stored per sample slot (packed into one RAM word)
//  DEPTH    240  sample slots; any value 2..2**ADDR_W (need not be a power of 2)
//  ADDR_W   8    address/offset width
//  CH_W     1    channel-select width, >= clog2(CHANNELS), minimum 1
// PORTS
//  clk        in  1                 single clock, all logic posedge
//  rst_n      in  1                 asynchronous, active-low reset
//  in_valid   in  1                 sample strobe
//  in_data    in  DATA_W*CHANNELS   channel c at [c*DATA_W +: DATA_W]
//  arm        in  1                 start/restart a capture (pulse)
//  trigger    in  1                 qualified by in_valid
//  post_len   in  ADDR_W            post-trigger samples, latched on arm, clipped to DEPTH-1
//  rd_en      in  1                 read request (honoured only in DONE)
//  rd_offset  in  ADDR_W            0 = oldest stored sample
//  rd_chan    in  CH_W              channel to return
//  rd_data    out DATA_W            read result, registered
//  rd_valid   out 1                 rd_data valid, 1 cycle after rd_en
//  busy       out 1                 high in FILL or POST
//  done       out 1                 high in DONE
//  trig_pos   out ADDR_W            offset of trigger sample from oldest; valid in DONE
// BEHAVIOUR
//  Reset: state=IDLE, wr_ptr=0, fill=0, post_cnt=0, rd_data=0, rd_valid=0, busy=0, done=0, trig_pos=0.
//    RAM is not cleared.
//  States: IDLE, FILL, POST, DONE. Writes happen only in FILL/POST with in_valid.
//  IDLE: arm -> FILL; wr_ptr=0, fill=0, latch post_len.
//  FILL: in_valid writes all channels at wr_ptr, wr_ptr wraps DEPTH-1 -> 0.
//    fill saturates at DEPTH.
//    in_valid&trigger: the trigger sample is written. If post_len==0 -> DONE, else POST with post_cnt=post_len.
//    A trigger is legal before the buffer is full.
//  POST: in_valid writes and decrements post_cnt; the write with post_cnt==1 -> DONE. trigger ignored.
//  DONE: frozen. oldest = (fill<DEPTH) ? 0 : wr_ptr. trig_pos = fill-1-post_len (latched value).
//  arm in any state (incl. FILL/POST/DONE) restarts as from IDLE. arm beats a same-cycle trigger.
//    A sample with in_valid in the arm cycle is not written.
//  Read: rd_en in DONE -> next cycle rd_valid=1, rd_data = word[(oldest+rd_offset) mod DEPTH] channel rd_chan.
//    Modulo is done by one compare/subtract, no % operator.
//    rd_offset>=fill -> rd_data=0. rd_en outside DONE -> rd_valid=0, rd_data held.
//    rd_chan>=CHANNELS -> 0.
//  Latency: write 1 cycle (data visible to reads from the following cycle); read 1 cycle.
//  rst_n low mid-capture aborts to IDLE immediately; done/busy fall asynchronously.
// STRUCTURE
//  Shared package: state encodings, clog2 helper.
//  Sub-module capture_ram: simple dual-port, 1 clk, DEPTH x DATA_W*CHANNELS, registered read.
//  Top holds the FSM, pointers and counters, the address adder/wrap, and the output channel mux.
// TESTING (DEPTH=240, CHANNELS=2, ch0=n, ch1=n^16'hFFFF for sample n)
//  1 Wrap: arm, in_valid every cycle, trigger on n=299, post_len=20
//    -> done after n=319, trig_pos=219, offset0=80, offset219=299, offset239=319, ch1 of offset0=~80.
//  2 Partial: trigger on n=150, post_len=20 -> fill=171, trig_pos=150, offset0=0, offset170=170, offset171 -> 0.
//  3 post_len=0, trigger on n=10 -> done next cycle, fill=11, trig_pos=10, offset10=10.
//  4 in_valid every 3rd cycle, trigger pulsed with in_valid=0 -> ignored; later qualified trigger captures correctly.
//  5 arm+trigger same cycle -> FILL, no capture; arm during POST -> restart, fill=0, done never rises early.
//  6 rst_n low in POST -> busy=0, done=0, rd_valid=0; rd_en after reset -> rd_valid stays 0.

Source files
------------

// File: rtl/trigger_capture_buffer_pkg.sv
// rtl/trigger_capture_buffer_pkg.sv - shared types and helpers for the trigger capture buffer
package trigger_capture_buffer_pkg;

    // Capture FSM: IDLE until armed, FILL records history, POST counts
    // post-trigger samples, DONE freezes the buffer for readout.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_POST = 2'd2,
        ST_DONE = 2'd3
    } tcb_state_t;

    // Ceiling log2, returns at least 1 so it can size a select field directly.
    function automatic int tcb_clog2(input int value);
        int result;
        result = 1;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/trigger_capture_buffer_capture_ram.sv
// rtl/trigger_capture_buffer_capture_ram.sv - simple dual-port sample RAM with registered read
//
// Purpose: DEPTH x WORD_W storage, one write port and one registered read port,
//          single clock. Contents are never cleared.
// Ports:
//   clk      clock
//   wr_en    write strobe, wr_data stored at wr_addr on the rising edge
//   wr_addr  write slot
//   wr_data  packed multi-channel sample word
//   rd_en    read strobe, rd_q loads mem[rd_addr] on the rising edge, else holds
//   rd_addr  read slot
//   rd_q     registered read word
module capture_ram #(
    parameter int DEPTH  = 240,
    parameter int ADDR_W = 8,
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_q
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_q <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/trigger_capture_buffer.sv
// rtl/trigger_capture_buffer.sv - multi-channel circular capture buffer with arm/trigger/post-trigger
//
// Purpose: continuously records pre-trigger history; after a qualified trigger stores
//          post_len more samples, then freezes for random-access readout.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_data   sample strobe and packed channels (channel c at [c*DATA_W +: DATA_W])
//   arm                 start/restart a capture; wins over a same-cycle trigger
//   trigger             trigger request, qualified by in_valid
//   post_len            post-trigger sample count, latched on arm, clipped to DEPTH-1
//   rd_en, rd_offset    read request (DONE only), offset 0 = oldest stored sample
//   rd_chan             channel to return
//   rd_data, rd_valid   read result one cycle after an accepted rd_en
//   busy, done          FILL/POST and DONE indicators
//   trig_pos            trigger sample offset from oldest, valid in DONE
module trigger_capture_buffer
    import trigger_capture_buffer_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int CHANNELS = 1,
    parameter int DEPTH    = 240,
    parameter int ADDR_W   = 8,
    parameter int CH_W     = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [DATA_W*CHANNELS-1:0] in_data,
    input  logic                       arm,
    input  logic                       trigger,
    input  logic [ADDR_W-1:0]          post_len,
    input  logic                       rd_en,
    input  logic [ADDR_W-1:0]          rd_offset,
    input  logic [CH_W-1:0]            rd_chan,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    output logic                       busy,
    output logic                       done,
    output logic [ADDR_W-1:0]          trig_pos
);

    localparam int WORD_W = DATA_W * CHANNELS;
    // One extra bit so fill can hold DEPTH even when DEPTH == 2**ADDR_W.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  MAXPOST_C = CNT_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] LAST_C    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] DEPTH_LO  = ADDR_W'(DEPTH);

    tcb_state_t        state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [CNT_W-1:0]  fill;
    logic [ADDR_W-1:0] post_cnt;
    logic [ADDR_W-1:0] post_len_q;

    logic              capturing;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_ptr_inc;
    logic [CNT_W-1:0]  fill_inc;
    logic [ADDR_W-1:0] trig_calc;
    logic [ADDR_W-1:0] post_len_clip;

    logic [ADDR_W-1:0] oldest;
    logic [CNT_W-1:0]  rd_sum;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_hit;
    logic              rd_zero;
    logic              rd_zero_q;
    logic [CH_W-1:0]   rd_chan_q;
    logic [WORD_W-1:0] ram_q;
    logic [DATA_W-1:0] chan_word;

    assign capturing  = (state == ST_FILL) || (state == ST_POST);
    // The sample arriving with arm belongs to the old capture and is dropped.
    assign wr_en      = capturing && in_valid && !arm;
    assign wr_ptr_inc = (wr_ptr == LAST_C) ? '0 : wr_ptr + 1'b1;
    assign fill_inc   = (fill == DEPTH_C) ? DEPTH_C : fill + 1'b1;
    // Evaluated on the final write; low bits suffice since the result is < DEPTH.
    assign trig_calc  = fill_inc[ADDR_W-1:0] - 1'b1 - post_len_q;

    assign post_len_clip = ({1'b0, post_len} >= MAXPOST_C) ? LAST_C : post_len;

    // Readout address: oldest + offset, wrapped by a single conditional subtract.
    assign oldest  = (fill < DEPTH_C) ? '0 : wr_ptr;
    assign rd_sum  = {1'b0, oldest} + {1'b0, rd_offset};
    assign rd_addr = (rd_sum >= DEPTH_C) ? (rd_sum[ADDR_W-1:0] - DEPTH_LO) : rd_sum[ADDR_W-1:0];
    assign rd_hit  = rd_en && (state == ST_DONE);
    assign rd_zero = ({1'b0, rd_offset} >= fill) || (int'(rd_chan) >= CHANNELS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            fill       <= '0;
            post_cnt   <= '0;
            post_len_q <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            trig_pos   <= '0;
        end else if (arm) begin
            state      <= ST_FILL;
            wr_ptr     <= '0;
            fill       <= '0;
            post_cnt   <= '0;
            post_len_q <= post_len_clip;
            busy       <= 1'b1;
            done       <= 1'b0;
            trig_pos   <= '0;
        end else begin
            case (state)
                ST_FILL: begin
                    if (in_valid) begin
                        wr_ptr <= wr_ptr_inc;
                        fill   <= fill_inc;
                        if (trigger) begin
                            if (post_len_q == '0) begin
                                state    <= ST_DONE;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                                trig_pos <= trig_calc;
                            end else begin
                                state    <= ST_POST;
                                post_cnt <= post_len_q;
                            end
                        end
                    end
                end
                ST_POST: begin
                    if (in_valid) begin
                        wr_ptr   <= wr_ptr_inc;
                        fill     <= fill_inc;
                        post_cnt <= post_cnt - 1'b1;
                        if (post_cnt == ADDR_W'(1)) begin
                            state    <= ST_DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            trig_pos <= trig_calc;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Read side flags; rd_zero_q starts set so rd_data reads 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid  <= 1'b0;
            rd_zero_q <= 1'b1;
            rd_chan_q <= '0;
        end else begin
            rd_valid <= rd_hit;
            if (rd_hit) begin
                rd_zero_q <= rd_zero;
                rd_chan_q <= rd_chan;
            end
        end
    end

    capture_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (in_data),
        .rd_en   (rd_hit),
        .rd_addr (rd_addr),
        .rd_q    (ram_q)
    );

    always_comb begin
        chan_word = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (rd_chan_q == CH_W'(c)) begin
                chan_word = ram_q[c*DATA_W +: DATA_W];
            end
        end
    end

    assign rd_data = rd_zero_q ? '0 : chan_word;

endmodule
